xoodoo_engine: RTL and testbench
================================

# xoodoo_engine

Iterative, parametrised Xoodoo permutation engine with a start/busy/done handshake, configurable unroll (rounds per clock) and a runtime choice between Xoodoo[12] and Xoodoo[6]. It replaces the free-running single-round `permute` core. The absorb, encrypt and squeeze stages of the Xoodyak datapath issue one 384-bit state per request and wait for `done`.

## Interface
- `RPC`, default 1: rounds evaluated per clock. Legal values are 1, 2, 3 and 6; any other value is an elaboration error.
- `eph1`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset), sampled on `eph1`.
- `start`  in  1  request; accepted only when `busy`=0.
- `short_mode`  in  1  sampled with an accepted `start`: 0 = 12 rounds, 1 = 6 rounds.
- `state_in`  in  384  input state; lane L = x+4y at bits [32L+31:32L] (plane y, column x); bit z of a lane is bit 32L+z.
- `state_out`  out  384  result register, same layout; holds its value until the next completion.
- `busy`  out  1  permutation in progress.
- `done`  out  1  one-cycle pulse when `state_out` is updated.

## Operation
- States: IDLE and RUN. The round index `ri` is 4 bits.
- IDLE, `start`=1:
  - load the working register with `state_in`;
  - set `ri` = 0 (12-round mode) or 6 (6-round mode);
  - go to RUN.
- RUN, each cycle:
  - apply rounds `ri` … `ri`+RPC−1 combinationally;
  - write the result back;
  - `ri` += RPC.
- When the new `ri` reaches 12:
  - write the result to `state_out`;
  - pulse `done`;
  - return to IDLE.
- Round constants, indexed by `ri` 0..11: 0x058, 0x038, 0x3C0, 0x0D0, 0x120, 0x014, 0x060, 0x02C, 0x380, 0x0F0, 0x1A0, 0x012. 6-round mode uses indices 6..11.
- Round definition (all rotations cyclic toward higher z):
  - theta: P[x] = A0[x]^A1[x]^A2[x]; E[x] = rot(P[x−1],5) ^ rot(P[x−1],14); Ay[x] ^= E[x].
  - rho-west: A1[x] ← A1[x−1]; A2[x] ← rot(A2[x],11).
  - iota: A0[0] ^= RC.
  - chi: A0 ^= ~A1&A2; A1 ^= ~A2&A0; A2 ^= ~A0&A1, all computed from pre-chi values.
  - rho-east: A1[x] ← rot(A1[x],1); A2[x] ← rot(A2[x−2],8).
  - All x indices are mod 4.
- `start` while `busy`=1 is ignored. `state_in` and `short_mode` are don't-care after acceptance.
- Reset mid-operation aborts the permutation:
  - no `done` pulse;
  - `state_out` cleared;
  - the next cycle is IDLE.

## Timing
- Reset values: `state_out`=0, `busy`=0, `done`=0, state=IDLE, `ri`=0.
- `start` accepted at edge k. `busy`=1 from k through k+N−1.
- At edge k+N: `done`=1, `busy`=0, `state_out` valid.
- N = 12/RPC cycles (12-round mode) or 6/RPC cycles (6-round mode). Example: RPC=1 gives 12 and 6; RPC=6 gives 2 and 1.
- Back-to-back operation: `start` asserted in the `done` cycle is accepted, because `busy`=0 in that cycle. Throughput is one permutation per N+1 cycles.
- `done` never stays high for two consecutive cycles.
- `start` with `reset`=0 is ignored; reset wins.

## Configuration
- `XOODOO_BYTESWAP_EN` defined:
  - `state_in` is byte-reversed within each 32-bit lane on load;
  - the result is byte-reversed again before it is written to `state_out`;
  - this matches byte-string (little-endian lane) ordering from the Xoodyak byte interface.
- Not defined: lanes pass through unmodified. Latency is identical in both cases.

## Structure
- Package `xoodoo_pkg` holds:
  - `typedef logic [2:0][3:0][31:0] xoodoo_state_t`;
  - the 12-entry round-constant array `XOODOO_RC`;
  - `localparam XOODOO_MAX_ROUNDS = 12`.
- Sub-module `xoodoo_round`: purely combinational single round with inputs state and rc and output state. It is instantiated RPC times in a chain, with constants selected by `ri`+i.
- The top level contains the FSM, the `ri` counter, the working register, `state_out` and the optional byteswap.

## Test plan
- Reset, then idle for 5 cycles: `state_out`=0, `busy`=0, `done`=0 throughout.
- RPC=1, all-zero `state_in`, `short_mode`=0, `start` at cycle 0:
  - `busy` high for cycles 0–11;
  - `done` pulse at cycle 12;
  - `state_out` equals Xoodoo[12](0) from the XKCP golden model.
- RPC=1, 6-round mode: with `state_in` lane0=0x00000001, others 0, `done` arrives after 6 cycles; result matches the golden model for rounds 6..11.
- Sweep RPC ∈ {1,2,3,6} over 200 random states per mode: results are identical across RPC values, and latency is 12/RPC or 6/RPC.
- `start` pulsed in the `done` cycle with a new state:
  - the second result is correct;
  - `start` asserted while `busy`=1 is ignored, confirmed by `state_out` being unchanged apart from the first job.
- `reset`=0 asserted at cycle 5 of a 12-round job: no `done`, `state_out`=0; a new job after reset completes correctly. Repeat with `XOODOO_BYTESWAP_EN` both defined and undefined.

Source files
------------

// File: rtl/xoodoo_pkg.sv
// Shared types, round constants and helpers for the Xoodoo permutation engine.
// The optional lane byteswap helper is used only when XOODOO_BYTESWAP_EN is defined.
package xoodoo_pkg;

  // Indexed [y][x]; lane x+4y sits at bits [32(x+4y)+31 : 32(x+4y)].
  typedef logic [2:0][3:0][31:0] xoodoo_state_t;

  localparam int XOODOO_MAX_ROUNDS = 12;

  localparam logic [31:0] XOODOO_RC [XOODOO_MAX_ROUNDS] = '{
    32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
    32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } eng_state_e;

  // Cyclic rotation toward higher z; n is always a constant 1..31.
  function automatic logic [31:0] xoodoo_rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Round constant lookup; indices past the last round never occur and read as zero.
  function automatic logic [31:0] xoodoo_rc(input logic [3:0] idx);
    logic [31:0] rc;
    rc = '0;
    if (int'(idx) < XOODOO_MAX_ROUNDS) rc = XOODOO_RC[idx];
    return rc;
  endfunction

  // Reverse byte order inside every 32-bit lane.
  function automatic xoodoo_state_t xoodoo_bswap(input xoodoo_state_t s);
    xoodoo_state_t r;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        r[y][x] = {s[y][x][7:0], s[y][x][15:8], s[y][x][23:16], s[y][x][31:24]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/xoodoo_round.sv
// One combinational Xoodoo round: theta, rho-west, iota, chi, rho-east.
module xoodoo_round
  import xoodoo_pkg::*;
(
  input  xoodoo_state_t state_i,
  input  logic [31:0]   rc_i,
  output xoodoo_state_t state_o
);

  logic [3:0][31:0] p;
  logic [3:0][31:0] e;
  xoodoo_state_t    th;
  xoodoo_state_t    rw;
  xoodoo_state_t    ch;

  // Full round evaluated step by step on plane/column slices.
  always_comb begin
    p       = '0;
    e       = '0;
    th      = '0;
    rw      = '0;
    ch      = '0;
    state_o = '0;

    // theta: column parity folded back in from the neighbouring column
    for (int x = 0; x < 4; x++) begin
      p[x] = state_i[0][x] ^ state_i[1][x] ^ state_i[2][x];
    end
    for (int x = 0; x < 4; x++) begin
      e[x] = xoodoo_rotl(p[2'(x + 3)], 5) ^ xoodoo_rotl(p[2'(x + 3)], 14);
    end
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        th[y][x] = state_i[y][x] ^ e[x];
      end
    end

    // rho-west: shift plane 1 along x, rotate plane 2 along z
    for (int x = 0; x < 4; x++) begin
      rw[0][x] = th[0][x];
      rw[1][x] = th[1][2'(x + 3)];
      rw[2][x] = xoodoo_rotl(th[2][x], 11);
    end

    // iota
    rw[0][0] = rw[0][0] ^ rc_i;

    // chi: every term uses the pre-chi planes
    for (int x = 0; x < 4; x++) begin
      ch[0][x] = rw[0][x] ^ (~rw[1][x] & rw[2][x]);
      ch[1][x] = rw[1][x] ^ (~rw[2][x] & rw[0][x]);
      ch[2][x] = rw[2][x] ^ (~rw[0][x] & rw[1][x]);
    end

    // rho-east
    for (int x = 0; x < 4; x++) begin
      state_o[0][x] = ch[0][x];
      state_o[1][x] = xoodoo_rotl(ch[1][x], 1);
      state_o[2][x] = xoodoo_rotl(ch[2][2'(x + 2)], 8);
    end
  end

endmodule

// File: rtl/xoodoo_engine.sv
// Iterative Xoodoo[12]/Xoodoo[6] engine, RPC rounds per clock, start/busy/done handshake.
// Define XOODOO_BYTESWAP_EN to byte-reverse each lane on load and again on the result.
module xoodoo_engine
  import xoodoo_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         eph1,
  input  logic         reset,
  input  logic         start,
  input  logic         short_mode,
  input  logic [383:0] state_in,
  output logic [383:0] state_out,
  output logic         busy,
  output logic         done
);

  if (!(RPC == 1 || RPC == 2 || RPC == 3 || RPC == 6)) begin : g_bad_rpc
    $error("xoodoo_engine: RPC must be 1, 2, 3 or 6");
  end

  eng_state_e             state_q, state_d;
  logic [3:0]             ri_q, ri_d, ri_step;
  xoodoo_state_t          work_q, work_d;
  logic [383:0]           state_out_q, state_out_d;
  logic                   done_q, done_d;
  xoodoo_state_t          load_state;
  xoodoo_state_t          result_state;
  xoodoo_state_t [RPC:0]  chain;

  assign chain[0] = work_q;

  // Round chain: stage i applies round ri+i.
  for (genvar i = 0; i < RPC; i++) begin : g_round
    xoodoo_round u_round (
      .state_i (chain[i]),
      .rc_i    (xoodoo_rc(ri_q + 4'(i))),
      .state_o (chain[i+1])
    );
  end

`ifdef XOODOO_BYTESWAP_EN
  assign load_state   = xoodoo_bswap(state_in);
  assign result_state = xoodoo_bswap(chain[RPC]);
`else
  assign load_state   = state_in;
  assign result_state = chain[RPC];
`endif

  // Next-state logic: load on start, iterate while running, publish on the last step.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value unassigned and infers a latch.
    state_d     = state_q;
    ri_d        = ri_q;
    work_d      = work_q;
    state_out_d = state_out_q;
    done_d      = 1'b0;
    ri_step     = ri_q + 4'(RPC);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d  = load_state;
          ri_d    = short_mode ? 4'(XOODOO_MAX_ROUNDS / 2) : 4'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d = chain[RPC];
        ri_d   = ri_step;
        if (ri_step == 4'(XOODOO_MAX_ROUNDS)) begin
          state_out_d = result_state;
          done_d      = 1'b1;
          ri_d        = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and result register with synchronous active-low reset.
  always_ff @(posedge eph1) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q     <= ST_IDLE;
      ri_q        <= '0;
      state_out_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ri_q        <= ri_d;
      state_out_q <= state_out_d;
      done_q      <= done_d;
    end
  end

  // Working register for the permutation state.
  always_ff @(posedge eph1) begin
    // NOTE: the wide datapath register is not reset; it is always loaded before it is used.
    work_q <= work_d;
  end

  assign state_out = state_out_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_xoodoo_engine.sv
// Self-checking bench: four engines (RPC 1, 2, 3, 6) against a lane-array reference model.
module tb_xoodoo_engine;

  localparam int ND = 4;

  localparam logic [31:0] MODEL_RC [12] = '{
    32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
    32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
  };

  typedef struct {
    logic         sm;
    logic [383:0] st;
    logic [383:0] exp;
  } vec_t;

  logic          eph1 = 1'b0;
  logic          reset;
  logic [ND-1:0] start_v;
  logic          short_mode;
  logic [383:0]  state_in;
  logic [383:0]  out_v [ND];
  logic [ND-1:0] busy_v;
  logic [ND-1:0] done_v;
  logic [383:0]  last_exp [ND];

  int errors = 0;
  int checks = 0;

  always #5 eph1 = ~eph1;

  xoodoo_engine #(.RPC(1)) u_rpc1 (
    .eph1(eph1), .reset(reset), .start(start_v[0]), .short_mode(short_mode),
    .state_in(state_in), .state_out(out_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  xoodoo_engine #(.RPC(2)) u_rpc2 (
    .eph1(eph1), .reset(reset), .start(start_v[1]), .short_mode(short_mode),
    .state_in(state_in), .state_out(out_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  xoodoo_engine #(.RPC(3)) u_rpc3 (
    .eph1(eph1), .reset(reset), .start(start_v[2]), .short_mode(short_mode),
    .state_in(state_in), .state_out(out_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  xoodoo_engine #(.RPC(6)) u_rpc6 (
    .eph1(eph1), .reset(reset), .start(start_v[3]), .short_mode(short_mode),
    .state_in(state_in), .state_out(out_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int rpc_of(input int d);
    case (d)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 6;
    endcase
  endfunction

  function automatic int lat_of(input int d, input logic sm);
    return (sm ? 6 : 12) / rpc_of(d);
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [383:0] rand_state();
    logic [383:0] s;
    for (int l = 0; l < 12; l++) s[32*l +: 32] = $urandom;
    return s;
  endfunction

  // Reference: Xoodoo rounds on a flat array of 12 lanes, index x+4y.
  function automatic logic [383:0] model(input logic [383:0] s_in, input logic sm);
    logic [31:0]  a [12];
    logic [31:0]  t [12];
    logic [31:0]  p [4];
    logic [31:0]  e;
    logic [383:0] r;
    for (int l = 0; l < 12; l++) begin
      a[l] = s_in[32*l +: 32];
`ifdef XOODOO_BYTESWAP_EN
      a[l] = bswap32(a[l]);
`endif
    end
    for (int rnd = (sm ? 6 : 0); rnd < 12; rnd++) begin
      for (int x = 0; x < 4; x++) p[x] = a[x] ^ a[x+4] ^ a[x+8];
      for (int i = 0; i < 12; i++) begin
        e = rol(p[(i + 3) % 4], 5) ^ rol(p[(i + 3) % 4], 14);
        a[i] = a[i] ^ e;
      end
      t = a;
      for (int x = 0; x < 4; x++) begin
        a[4+x] = t[4 + (x + 3) % 4];
        a[8+x] = rol(t[8+x], 11);
      end
      a[0] = a[0] ^ MODEL_RC[rnd];
      t = a;
      for (int x = 0; x < 4; x++) begin
        a[x]   = t[x]   ^ (~t[4+x] & t[8+x]);
        a[4+x] = t[4+x] ^ (~t[8+x] & t[x]);
        a[8+x] = t[8+x] ^ (~t[x]   & t[4+x]);
      end
      t = a;
      for (int x = 0; x < 4; x++) begin
        a[4+x] = rol(t[4+x], 1);
        a[8+x] = rol(t[8 + (x + 2) % 4], 8);
      end
    end
    for (int l = 0; l < 12; l++) begin
`ifdef XOODOO_BYTESWAP_EN
      r[32*l +: 32] = bswap32(a[l]);
`else
      r[32*l +: 32] = a[l];
`endif
    end
    return r;
  endfunction

  // Issue one job to the engines in mask and check busy, latency, pulse count and result.
  task automatic run_job(input logic [ND-1:0] mask, input logic sm, input logic [383:0] st,
                         input logic [383:0] exp, input string tag);
    int first [ND];
    int pulses [ND];
    for (int d = 0; d < ND; d++) begin
      first[d]  = -1;
      pulses[d] = 0;
    end
    @(negedge eph1);
    start_v    = mask;
    short_mode = sm;
    state_in   = st;
    for (int j = 0; j <= 14; j++) begin
      @(negedge eph1);
      if (j == 0) begin
        start_v    = '0;
        short_mode = ~sm;
        state_in   = rand_state();
      end
      for (int d = 0; d < ND; d++) begin
        if (mask[d]) begin
          if (j == 0)
            check($sformatf("%s busy_after_accept rpc%0d", tag, rpc_of(d)), busy_v[d], 1'b1);
          if (j == lat_of(d, sm))
            check($sformatf("%s busy_at_done rpc%0d", tag, rpc_of(d)), busy_v[d], 1'b0);
          if (done_v[d]) begin
            pulses[d]++;
            if (first[d] < 0) first[d] = j;
          end
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      if (mask[d]) begin
        check($sformatf("%s latency rpc%0d", tag, rpc_of(d)), 384'(first[d]), 384'(lat_of(d, sm)));
        check($sformatf("%s done_pulses rpc%0d", tag, rpc_of(d)), 384'(pulses[d]), 384'd1);
        check($sformatf("%s result rpc%0d", tag, rpc_of(d)), out_v[d], exp);
        last_exp[d] = exp;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [8];
    logic [383:0] sa, sb, sc, exp_a, exp_b;
    int           pulses [ND];

    reset      = 1'b0;
    start_v    = '0;
    short_mode = 1'b0;
    state_in   = '0;
    for (int d = 0; d < ND; d++) last_exp[d] = '0;

    // Directed vectors: zero, single bit, all ones, pattern, in both modes.
    for (int i = 0; i < 8; i++) begin
      vecs[i].sm = i[0];
      case (i / 2)
        0: vecs[i].st = '0;
        1: vecs[i].st = 384'h1;
        2: vecs[i].st = '1;
        default: vecs[i].st = {12{32'h01234567}} ^ {{11{32'h0}}, 32'hDEADBEEF};
      endcase
      vecs[i].exp = model(vecs[i].st, vecs[i].sm);
    end

    // Reset state, held and then idle for 5 cycles.
    repeat (3) @(negedge eph1);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("in_reset out rpc%0d", rpc_of(d)), out_v[d], '0);
      check($sformatf("in_reset busy rpc%0d", rpc_of(d)), busy_v[d], 1'b0);
      check($sformatf("in_reset done rpc%0d", rpc_of(d)), done_v[d], 1'b0);
    end
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge eph1);
      for (int d = 0; d < ND; d++) begin
        check($sformatf("idle%0d out rpc%0d", c, rpc_of(d)), out_v[d], '0);
        check($sformatf("idle%0d busy rpc%0d", c, rpc_of(d)), busy_v[d], 1'b0);
        check($sformatf("idle%0d done rpc%0d", c, rpc_of(d)), done_v[d], 1'b0);
      end
    end

    for (int i = 0; i < 8; i++)
      run_job('1, vecs[i].sm, vecs[i].st, vecs[i].exp, $sformatf("vec%0d", i));

    for (int n = 0; n < 400; n++) begin
      sa = rand_state();
      run_job('1, n[0], sa, model(sa, n[0]), $sformatf("rand%0d", n));
    end

    // Back-to-back on the RPC=1 engine, with an ignored start while busy.
    sa    = rand_state();
    sb    = rand_state();
    sc    = rand_state();
    exp_a = model(sa, 1'b0);
    exp_b = model(sb, 1'b1);
    @(negedge eph1);
    start_v    = 4'b0001;
    short_mode = 1'b0;
    state_in   = sa;
    @(negedge eph1);
    start_v = '0;
    check("b2b busy_first", busy_v[0], 1'b1);
    repeat (2) @(negedge eph1);
    start_v    = 4'b0001;
    short_mode = 1'b1;
    state_in   = sc;
    repeat (3) @(negedge eph1);
    start_v = '0;
    repeat (6) @(negedge eph1);
    check("b2b no_early_done", done_v[0], 1'b0);
    check("b2b busy_before_done", busy_v[0], 1'b1);
    check("b2b out_held", out_v[0], last_exp[0]);
    @(negedge eph1);
    check("b2b done_a", done_v[0], 1'b1);
    check("b2b busy_at_done_a", busy_v[0], 1'b0);
    check("b2b result_a", out_v[0], exp_a);
    last_exp[0] = exp_a;
    start_v    = 4'b0001;
    short_mode = 1'b1;
    state_in   = sb;
    @(negedge eph1);
    start_v  = '0;
    state_in = rand_state();
    check("b2b done_not_stretched", done_v[0], 1'b0);
    check("b2b busy_second", busy_v[0], 1'b1);
    repeat (5) @(negedge eph1);
    check("b2b no_early_done_b", done_v[0], 1'b0);
    @(negedge eph1);
    check("b2b done_b", done_v[0], 1'b1);
    check("b2b result_b", out_v[0], exp_b);
    last_exp[0] = exp_b;

    // Reset at cycle 5 of a 12-round job aborts it and clears the result.
    @(negedge eph1);
    start_v    = '1;
    short_mode = 1'b0;
    state_in   = rand_state();
    @(negedge eph1);
    start_v = '0;
    repeat (4) @(negedge eph1);
    reset = 1'b0;
    @(negedge eph1);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("abort done rpc%0d", rpc_of(d)), done_v[d], 1'b0);
      check($sformatf("abort busy rpc%0d", rpc_of(d)), busy_v[d], 1'b0);
      check($sformatf("abort out rpc%0d", rpc_of(d)), out_v[d], '0);
      last_exp[d] = '0;
    end
    start_v  = '1;
    state_in = rand_state();
    @(negedge eph1);
    for (int d = 0; d < ND; d++)
      check($sformatf("start_in_reset busy rpc%0d", rpc_of(d)), busy_v[d], 1'b0);
    reset   = 1'b1;
    start_v = '0;
    for (int d = 0; d < ND; d++) pulses[d] = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge eph1);
      for (int d = 0; d < ND; d++) if (done_v[d]) pulses[d]++;
    end
    for (int d = 0; d < ND; d++) begin
      check($sformatf("abort no_done rpc%0d", rpc_of(d)), 384'(pulses[d]), 384'd0);
      check($sformatf("abort out_held rpc%0d", rpc_of(d)), out_v[d], '0);
    end
    sa = rand_state();
    run_job('1, 1'b0, sa, model(sa, 1'b0), "after_reset12");
    sa = rand_state();
    run_job('1, 1'b1, sa, model(sa, 1'b1), "after_reset6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
